// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one adder reused over AW iterations, start/busy/done handshake.
// Optional MULT_SEQ_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl #(
  parameter int AW = 3,
  parameter int BW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  a,
  input  logic [BW-1:0]  b,
  output logic           busy,
  output logic           done,
  output logic [AW+BW-1:0] product
);
  localparam int PW = AW + BW;
  localparam int CW = (AW > 1) ? $clog2(AW) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(AW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] a_reg;
  logic [BW-1:0] b_reg;
  logic [PW-1:0] acc, acc_nxt, addend;
  logic [CW-1:0] cnt;
  logic          accept, last;

  // start is only honoured when no operation is in flight
  assign accept = start && (state == S_IDLE || state == S_DONE);

  assign addend  = a_reg[cnt] ? ({{AW{1'b0}}, b_reg} << cnt) : '0;
  assign acc_nxt = acc + addend;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Current iteration is the last one if no multiplier bit above cnt is set.
  logic hi_zero;
  assign hi_zero = ((a_reg >> cnt) >> 1) == '0;
  assign last    = (cnt == LAST_CNT) || hi_zero;
`else
  assign last    = (cnt == LAST_CNT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = last ? S_DONE : S_RUN;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) product <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: vector table of single ops plus hand-written handshake corner cases.
module tb_mult_seq_ctrl;
  localparam int AW = 3;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          busy, done;
  logic [AW+BW-1:0] product;

  int tests = 0;
  int fails = 0;

  mult_seq_ctrl #(.AW(AW), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    int            prod;
    int            lat_fixed;
    int            lat_early;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int lat_of(input vec_t v);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    return v.lat_early;
`else
    return v.lat_fixed;
`endif
  endfunction

  // Counts busy cycles after the start edge; bounded so a stuck DUT still ends.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = ~v.b;  // changes during RUN must not matter
    wait_busy(n);
    chk({tag, " latency"}, n, lat_of(v));
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " product"}, int'(product), v.prod);
    @(negedge clk);
    chk({tag, " done_fall"}, int'(done), 0);
    chk({tag, " hold"}, int'(product), v.prod);
  endtask

  initial begin
    int n;
    vecs[0] = '{3'd5, 4'd11, 55, 3, 3};
    vecs[1] = '{3'd7, 4'd15, 105, 3, 3};
    vecs[2] = '{3'd0, 4'd9, 0, 3, 1};
    vecs[3] = '{3'd1, 4'd9, 9, 3, 1};
    vecs[4] = '{3'd2, 4'd3, 6, 3, 2};
    vecs[5] = '{3'd4, 4'd15, 60, 3, 3};
    vecs[6] = '{3'd6, 4'd2, 12, 3, 3};
    vecs[7] = '{3'd3, 4'd4, 12, 3, 2};
    vecs[8] = '{3'd7, 4'd0, 0, 3, 3};
    vecs[9] = '{3'd1, 4'd13, 13, 3, 1};

    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset product", int'(product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", int'(busy), 0);

    // first op checked cycle by cycle
    start = 1'b1; a = 3'd5; b = 4'd11;
    @(negedge clk);
    start = 1'b0;
    chk("t1 busy c1", int'(busy), 1);
    chk("t1 done c1", int'(done), 0);
    @(negedge clk);
    chk("t1 busy c2", int'(busy), 1);
    @(negedge clk);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    chk("t1 busy c3", int'(busy), 1);
`else
    chk("t1 busy c3", int'(busy), 1);
`endif
    chk("t1 product before done", int'(product), 0);
    @(negedge clk);
    chk("t1 done", int'(done), 1);
    chk("t1 busy off", int'(busy), 0);
    chk("t1 product", int'(product), 55);
    @(negedge clk);
    chk("t1 done_fall", int'(done), 0);

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // start re-asserted mid-RUN is ignored
    @(negedge clk);
    start = 1'b1; a = 3'd3; b = 4'd4;
    @(negedge clk);
    a = 3'd2; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (busy && n < 20) begin n++; @(negedge clk); end
`ifdef MULT_SEQ_EARLY_EXIT_EN
    chk("midrun latency", n, 2);
`else
    chk("midrun latency", n, 3);
`endif
    chk("midrun product", int'(product), 12);
    @(negedge clk);
    chk("midrun no second op", int'(busy), 0);
    chk("midrun done_fall", int'(done), 0);

    // start held high: DONE goes straight back to RUN
    @(negedge clk);
    start = 1'b1; a = 3'd6; b = 4'd2;
    @(negedge clk);
    wait_busy(n);
    chk("b2b first latency", n, 3);
    chk("b2b first done", int'(done), 1);
    chk("b2b first product", int'(product), 12);
    a = 3'd1; b = 4'd13;
    @(negedge clk);
    chk("b2b no idle busy", int'(busy), 1);
    chk("b2b done single", int'(done), 0);
    start = 1'b0;
    wait_busy(n);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    chk("b2b second latency", n, 1);
`else
    chk("b2b second latency", n, 3);
`endif
    chk("b2b second done", int'(done), 1);
    chk("b2b second product", int'(product), 13);
    @(negedge clk);
    chk("b2b idle after", int'(busy), 0);

    // reset during RUN aborts with no done pulse
    start = 1'b1; a = 3'd3; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("abort running", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort product", int'(product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("abort no activity", n, 0);
    chk("abort product held", int'(product), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
